// File: rtl/aes_pipelined.sv
// AES-128 encryption, fully unrolled: ten round stages, each registering its
// state together with its round key so every block carries its own key.
// Latency is ten enabled edges; data_out is the last stage register.
module aes_pipelined (
  output logic [127:0] data_out,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  input  logic         clk,
  input  logic         en,
  input  logic         clr
);

  // ---------------- GF(2^8) and S-box helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      else      acc = acc;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed as multiplicative inverse (b^254, zero maps to zero)
  // followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x12, x14, x15, x240, inv;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(x240, x14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- Round building blocks ----------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r of column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    else       t = t;
    return t ^ rk;
  endfunction

  // ---------------- Pipeline ----------------
  logic [127:0] st_q [1:10];
  logic [127:0] st_d [1:10];
  logic [127:0] rk_q [1:9];
  logic [127:0] rk_d [1:9];

  for (genvar r = 1; r <= 10; r++) begin : g_round
    logic [127:0] s_in;
    logic [127:0] k_in;
    logic [127:0] k_out;
    if (r == 1) begin : g_first
      assign s_in = data_in ^ key;
      assign k_in = key;
    end else begin : g_next
      assign s_in = st_q[r-1];
      assign k_in = rk_q[r-1];
    end
    assign k_out   = next_key(k_in, rcon(4'(r)));
    assign st_d[r] = aes_round(s_in, k_out, (r == 10));
    // The last stage's round key has no consumer, so only rounds 1..9 keep it.
    if (r < 10) begin : g_keep_key
      assign rk_d[r] = k_out;
    end
  end

  // Stage registers: clr low clears everything and wins over en; en low holds.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 1; i <= 10; i++) st_q[i] <= 128'h0;
      for (int i = 1; i <= 9; i++)  rk_q[i] <= 128'h0;
    end else if (en) begin
      for (int i = 1; i <= 10; i++) st_q[i] <= st_d[i];
      for (int i = 1; i <= 9; i++)  rk_q[i] <= rk_d[i];
    end else begin
      for (int i = 1; i <= 10; i++) st_q[i] <= st_q[i];
      for (int i = 1; i <= 9; i++)  rk_q[i] <= rk_q[i];
    end
  end

  assign data_out = st_q[10];

endmodule

// File: tb/tb_aes_pipelined.sv
// Directed and streaming checks for the AES-128 pipeline. Known-answer
// vectors come from FIPS-197; streaming blocks are checked against a
// byte-level software model whose S-box is built with the generator-3 walk.
module tb_aes_pipelined;

  logic [127:0] data_out;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         clk;
  logic         en;
  logic         clr;

  aes_pipelined dut (
    .data_out (data_out),
    .data_in  (data_in),
    .key      (key),
    .clk      (clk),
    .en       (en),
    .clr      (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];
  logic [7:0] sb [256];

  localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- software model ----------------
  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] s [16];
    logic [7:0] w [16];
    logic [7:0] t [16];
    logic [7:0] tw [4];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    for (int r = 1; r <= 10; r++) begin
      tw[0] = sb[w[13]] ^ rc;
      tw[1] = sb[w[14]];
      tw[2] = sb[w[15]];
      tw[3] = sb[w[12]];
      for (int i = 0; i < 4; i++) w[i] = w[i] ^ tw[i];
      for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
      rc = mul2(rc);
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          t[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[i];
    end
    res = 128'h0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp,
                       input bit want_eq);
    total++;
    if (want_eq && (act !== exp)) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end else if (!want_eq && (act === exp)) begin
      bad++;
      $display("FAIL %s: got %h, required anything but %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] k, input logic [127:0] p);
    key     = k;
    data_in = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [127:0] exp_q [100];

  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, CT_ZERO};
    build_sbox();

    // Reset state
    en = 1'b1; clr = 1'b0; drive(vecs[0].key, vecs[0].pt);
    tick(); tick();
    check("reset_zero", data_out, 128'h0, 1'b1);
    clr = 1'b1;

    // Known-answer vectors: ciphertext after the 10th edge, not the 9th
    for (int v = 0; v < 3; v++) begin
      drive(vecs[v].key, vecs[v].pt);
      tick();
      drive(vecs[v].key, ~vecs[v].pt);
      for (int e = 2; e <= 9; e++) tick();
      check($sformatf("kat%0d_early", v), data_out, vecs[v].ct, 1'b0);
      tick();
      check($sformatf("kat%0d", v), data_out, vecs[v].ct, 1'b1);
    end

    // Back-to-back blocks with different keys
    drive(vecs[0].key, vecs[0].pt); tick();
    drive(vecs[1].key, vecs[1].pt); tick();
    drive(128'h0, 128'h0);
    for (int e = 3; e <= 10; e++) tick();
    check("b2b_first", data_out, vecs[0].ct, 1'b1);
    tick();
    check("b2b_second", data_out, vecs[1].ct, 1'b1);

    // Stall: vector 2 is at the output while vector 1 is frozen mid-flight
    drive(vecs[1].key, vecs[1].pt); tick();
    drive(128'h0, 128'h0);
    for (int e = 0; e < 5; e++) tick();
    drive(vecs[0].key, vecs[0].pt); tick();
    drive(128'h0, 128'h0);
    for (int e = 0; e < 3; e++) tick();
    check("stall_pre", data_out, vecs[1].ct, 1'b1);
    en = 1'b0;
    for (int e = 0; e < 5; e++) begin
      drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      tick();
      check($sformatf("stall_hold%0d", e), data_out, vecs[1].ct, 1'b1);
    end
    en = 1'b1;
    drive(128'h0, 128'h0);
    for (int e = 0; e < 5; e++) tick();
    check("stall_early", data_out, vecs[0].ct, 1'b0);
    tick();
    check("stall_done", data_out, vecs[0].ct, 1'b1);

    // Mid-flow reset flushes in-flight blocks; reset also wins with en low
    drive(vecs[0].key, vecs[0].pt); tick();
    drive(128'h0, 128'h0);
    for (int e = 0; e < 3; e++) tick();
    clr = 1'b0; tick();
    check("midreset_zero", data_out, 128'h0, 1'b1);
    en = 1'b0; tick();
    check("reset_over_en", data_out, 128'h0, 1'b1);
    clr = 1'b1; en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e < 10) check($sformatf("flush%0d", e), data_out, vecs[0].ct, 1'b0);
      else        check($sformatf("post_reset%0d", e), data_out, CT_ZERO, 1'b1);
    end

    // Sustained streaming, a fresh key and block every cycle
    for (int j = 0; j < 109; j++) begin
      if (j < 100) begin
        drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        exp_q[j] = model_aes(key, data_in);
      end else begin
        drive(128'h0, 128'h0);
      end
      tick();
      if (j >= 9) check($sformatf("stream%0d", j - 9), data_out, exp_q[j-9], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
